dffnrsnq_ctl_seq: RTL and testbench

Registered clear/set sequencer that drives the RN and SETN pins of a bank of negative-edge set/reset flops (dffnrsnq family). It takes asynchronous clear/set requests, synchronizes them, and issues glitch-free, minimum-width, mutually exclusive active-low pulses. It completes each request with a four-phase REQ/ACK handshake. It sits directly upstream of the flop bank and is the only legal driver of its RN/SETN nets.

---
 rtl/dffnrsnq_ctl_seq.sv | 157 +++++++++++++++
 tb/tb_dffnrsnq_ctl_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dffnrsnq_ctl_seq.sv
// dffnrsnq_ctl_seq: registered clear/set sequencer for a bank of dffnrsnq flops.
// Synchronizes asynchronous four-phase clear/set requests and issues mutually
// exclusive, fixed-width active-low RN/SETN pulses followed by a dead-time gap
// and an ACK that is held until the serviced request drops.
// Build option: define DFFNRSNQ_CTL_SETPATH_EN to compile in the set path
// (REQ_S synchronizer, set-pulse state, SETN flop). Otherwise SETN is tied high.
`timescale 1ns / 1ps

module dffnrsnq_ctl_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic VDD,
    input  logic VSS,
    input  logic REQ_R,
    input  logic REQ_S,
    output logic RN,
    output logic SETN,
    output logic ACK,
    output logic BUSY
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
        $error("PULSE_CYCLES must be in 1..255");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..15");
    end

    // Counters count down to zero, so load N-1 to spend exactly N cycles in a state.
    localparam logic [7:0] PulseLoad = 8'(PULSE_CYCLES - 1);
    localparam logic [3:0] GapLoad   = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPulseR,
`ifdef DFFNRSNQ_CTL_SETPATH_EN
        StPulseS,
`endif
        StGap,
        StDone
    } state_t;

    state_t                 state_q;
    logic [7:0]             pulse_cnt_q;
    logic [3:0]             gap_cnt_q;
    logic [SYNC_STAGES-1:0] sync_r_q;
    logic                   r_s;
    logic                   rn_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   srv_lvl;

    assign r_s = sync_r_q[SYNC_STAGES-1];

    // Clear-request synchronizer chain.
    always_ff @(posedge CLK) begin
        if (RST) sync_r_q <= '0;
        else     sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], REQ_R};
    end

`ifdef DFFNRSNQ_CTL_SETPATH_EN
    logic [SYNC_STAGES-1:0] sync_s_q;
    logic                   s_s;
    logic                   srv_set_q;
    logic                   setn_q;
    logic                   unused_in;

    assign s_s       = sync_s_q[SYNC_STAGES-1];
    assign srv_lvl   = srv_set_q ? s_s : r_s;
    assign SETN      = setn_q;
    assign unused_in = VDD ^ VSS;

    // Set-request synchronizer chain.
    always_ff @(posedge CLK) begin
        if (RST) sync_s_q <= '0;
        else     sync_s_q <= {sync_s_q[SYNC_STAGES-2:0], REQ_S};
    end
`else
    logic unused_in;

    assign srv_lvl   = r_s;
    assign SETN      = 1'b1;
    assign unused_in = VDD ^ VSS ^ REQ_S;
`endif

    assign RN   = rn_q;
    assign ACK  = ack_q;
    assign BUSY = busy_q;

    // Sequencer FSM; pin outputs are registered from the current state so
    // they change only on the rising edge and never glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            pulse_cnt_q <= '0;
            gap_cnt_q   <= '0;
            rn_q        <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DFFNRSNQ_CTL_SETPATH_EN
            srv_set_q   <= 1'b0;
            setn_q      <= 1'b1;
`endif
        end else begin
            rn_q   <= (state_q != StPulseR);
            ack_q  <= (state_q == StDone);
            busy_q <= (state_q != StIdle);
`ifdef DFFNRSNQ_CTL_SETPATH_EN
            setn_q <= (state_q != StPulseS);
`endif
            unique case (state_q)
                StIdle: begin
                    // Clear has priority; the losing request is picked up on return.
                    if (r_s) begin
                        state_q     <= StPulseR;
                        pulse_cnt_q <= PulseLoad;
`ifdef DFFNRSNQ_CTL_SETPATH_EN
                        srv_set_q   <= 1'b0;
                    end else if (s_s) begin
                        state_q     <= StPulseS;
                        pulse_cnt_q <= PulseLoad;
                        srv_set_q   <= 1'b1;
`endif
                    end
                end
`ifdef DFFNRSNQ_CTL_SETPATH_EN
                StPulseR, StPulseS: begin
`else
                StPulseR: begin
`endif
                    if (pulse_cnt_q == 8'd0) begin
                        state_q   <= StGap;
                        gap_cnt_q <= GapLoad;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) state_q <= StDone;
                    else                   gap_cnt_q <= gap_cnt_q - 4'd1;
                end
                StDone: begin
                    if (!srv_lvl) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dffnrsnq_ctl_seq.sv
// Self-checking bench for dffnrsnq_ctl_seq: reset/clear vector table, reset
// mid-pulse, set-path behaviour, a parameter-sweep instance and a randomized
// run against a transaction-level reference model.
`timescale 1ns / 1ps

module tb_dffnrsnq_ctl_seq;

`ifdef DFFNRSNQ_CTL_SETPATH_EN
    localparam bit SetPath = 1'b1;
`else
    localparam bit SetPath = 1'b0;
`endif
    localparam int S     = 2;
    localparam int P     = 4;
    localparam int G     = 1;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vdd = 1'b1;
    logic vss = 1'b0;
    logic req_r = 1'b0, req_s = 1'b0;
    logic req_r2 = 1'b0, req_s2 = 1'b0;
    logic rn, setn, ack, busy;
    logic rn2, setn2, ack2, busy2;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        bit rst; bit rr; bit rs;
        bit rn;  bit setn; bit ack; bit busy;
    } vec_t;
    vec_t tbl[$];

    bit rq_r[NRAND], rq_s[NRAND];
    bit e_rn[NRAND], e_setn[NRAND], e_ack[NRAND], e_busy[NRAND];

    dffnrsnq_ctl_seq dut (
        .CLK (clk), .RST (rst), .VDD (vdd), .VSS (vss),
        .REQ_R (req_r), .REQ_S (req_s),
        .RN (rn), .SETN (setn), .ACK (ack), .BUSY (busy)
    );

    dffnrsnq_ctl_seq #(
        .SYNC_STAGES (4), .PULSE_CYCLES (1), .GAP_CYCLES (15)
    ) dut2 (
        .CLK (clk), .RST (rst), .VDD (vdd), .VSS (vss),
        .REQ_R (req_r2), .REQ_S (req_s2),
        .RN (rn2), .SETN (setn2), .ACK (ack2), .BUSY (busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit a, input bit b,
                       input bit x_rn, input bit x_setn, input bit x_ack, input bit x_busy);
        tbl.push_back('{r, a, b, x_rn, x_setn, x_ack, x_busy});
    endtask

    initial begin
        int n, w, t, d;
        bit cr, cs, is_set, lvl_r, lvl_s;
        int hr, hs;

        // Reset with both requests high, then a single clear (defaults S=2,P=4,G=1).
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 1, 1, 1);
        add(0, 1, 0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst   = tbl[i].rst;
            req_r = tbl[i].rr;
            req_s = tbl[i].rs;
            step();
            chk($sformatf("tbl%0d_rn", i),   rn,   tbl[i].rn);
            chk($sformatf("tbl%0d_setn", i), setn, tbl[i].setn);
            chk($sformatf("tbl%0d_ack", i),  ack,  tbl[i].ack);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
        end

        // Reset at the second pulse cycle truncates the pulse.
        req_r = 1'b1;
        n = 0;
        while (rn !== 1'b0 && n < 10) begin step(); n++; end
        chk("rstmid_start", rn, 1'b0);
        step();
        chk("rstmid_cyc2", rn, 1'b0);
        rst = 1'b1; req_r = 1'b0;
        step();
        chk("rstmid_rn", rn, 1'b1);
        chk("rstmid_ack", ack, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstmid_idle_rn", rn, 1'b1);
            chk("rstmid_idle_busy", busy, 1'b0);
        end

`ifdef DFFNRSNQ_CTL_SETPATH_EN
        // Simultaneous requests: clear first, set after clear is released.
        req_r = 1'b1; req_s = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 40) begin
            step(); n++;
            chk("sim_setn_hold", setn, 1'b1);
            chk("sim_excl", rn | setn, 1'b1);
        end
        chk("sim_ack", ack, 1'b1);
        req_r = 1'b0;
        n = 0;
        while (setn !== 1'b0 && n < 40) begin
            step(); n++;
            chk("sim_excl2", rn | setn, 1'b1);
        end
        chk("sim_set_follows", setn, 1'b0);
        w = 0;
        while (setn === 1'b0 && w < 20) begin step(); w++; end
        chk_int("sim_set_width", w, P);
        req_s = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin step(); n++; end
        chk("sim_busy_end", busy, 1'b0);
`else
        // Set path absent: REQ_S must have no effect.
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) req_s = ~req_s;
            step();
            chk("noset_setn", setn, 1'b1);
            chk("noset_ack", ack, 1'b0);
            chk("noset_busy", busy, 1'b0);
        end
        req_s = 1'b0;
        for (int i = 0; i < 6; i++) step();
`endif

        // Parameter sweep instance: S=4, P=1, G=15.
        req_r2 = 1'b1;
        n = 0;
        while (rn2 !== 1'b0 && n < 20) begin step(); n++; end
        chk_int("sweep_latency", n - 1, 5);
        w = 0;
        while (rn2 === 1'b0 && w < 10) begin step(); w++; end
        chk_int("sweep_width", w, 1);
        n = 0;
        while (ack2 !== 1'b1 && n < 40) begin step(); n++; end
        chk_int("sweep_gap", n, 15);
        req_r2 = 1'b0;
        n = 0;
        while (ack2 !== 1'b0 && n < 20) begin step(); n++; end
        chk_int("sweep_ack_release", n - 1, 5);
        chk("sweep_busy", busy2, 1'b0);

        // Randomized run: levels held for random lengths.
        lvl_r = 0; lvl_s = 0; hr = 0; hs = 0;
        for (int k = 0; k < NRAND; k++) begin
            if (hr == 0) begin lvl_r = ~lvl_r; hr = $urandom_range(1, 30); end
            if (hs == 0) begin lvl_s = ~lvl_s; hs = $urandom_range(1, 40); end
            hr--; hs--;
            rq_r[k] = lvl_r; rq_s[k] = lvl_s;
            e_rn[k] = 1; e_setn[k] = 1; e_ack[k] = 0; e_busy[k] = 0;
        end

        // Reference model: the FSM decides at edge t on requests sampled at t-S.
        // A transaction started at t pulses on edges t+1..t+P, ACKs from t+P+G+1,
        // and ends at the first edge d >= t+P+G+1 whose synchronized level is 0.
        t = 0;
        while (t < NRAND) begin
            cr = (t >= S) ? rq_r[t-S] : 1'b0;
            cs = (SetPath && t >= S) ? rq_s[t-S] : 1'b0;
            if (!cr && !cs) begin
                t++;
            end else begin
                is_set = !cr;
                for (int k = t + 1; k <= t + P && k < NRAND; k++) begin
                    if (is_set) e_setn[k] = 0;
                    else        e_rn[k] = 0;
                end
                d = t + P + G + 1;
                while (d < NRAND && (is_set ? rq_s[d-S] : rq_r[d-S])) d++;
                for (int k = t + 1; k <= d && k < NRAND; k++) e_busy[k] = 1;
                for (int k = t + P + G + 1; k <= d && k < NRAND; k++) e_ack[k] = 1;
                t = d + 1;
            end
        end

        rst = 1'b1; req_r = 1'b0; req_s = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < NRAND; k++) begin
            req_r = rq_r[k];
            req_s = rq_s[k];
            step();
            chk($sformatf("rnd%0d_rn", k),   rn,   e_rn[k]);
            chk($sformatf("rnd%0d_setn", k), setn, e_setn[k]);
            chk($sformatf("rnd%0d_ack", k),  ack,  e_ack[k]);
            chk($sformatf("rnd%0d_busy", k), busy, e_busy[k]);
            chk($sformatf("rnd%0d_excl", k), rn | setn, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
